// File: rtl/pc_redirect_unit.sv
// IF-stage PC register with branch redirect. A branch that resolves while the
// front end is frozen is parked in savedTarget and applied on release.
`ifndef WORD_LEN
`define WORD_LEN 32
`endif

module pc_redirect_unit #(
  parameter int                  WORD_LEN = `WORD_LEN,
  parameter logic [WORD_LEN-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                freeze,
  input  logic                brCond,
  input  logic [WORD_LEN-1:0] brTarget,
  output logic [WORD_LEN-1:0] pc,
  output logic [WORD_LEN-1:0] pcPlus4,
  output logic                flush,
  output logic                redirectPending,
  output logic [15:0]         takenCount
);

  typedef enum logic {RUN, PENDING} state_t;

  state_t              state_q, state_d;
  logic [WORD_LEN-1:0] pc_q, pc_d;
  logic [WORD_LEN-1:0] saved_target_q, saved_target_d;
  logic [15:0]         taken_count_q, taken_count_d;
  logic                flush_d;

  assign pcPlus4 = pc_q + WORD_LEN'(4);

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    saved_target_d = saved_target_q;
    taken_count_d  = taken_count_q;
    flush_d        = 1'b0;
    case (state_q)
      RUN: begin
        if (brCond && (taken_count_q != 16'hFFFF))
          taken_count_d = taken_count_q + 16'd1;
        if (brCond && freeze) begin
          saved_target_d = brTarget;
          state_d        = PENDING;
        end else if (brCond) begin
          pc_d    = brTarget;
          flush_d = 1'b1;
        end else if (!freeze) begin
          pc_d = pcPlus4;
        end
      end
      PENDING: begin
        // The frozen ID stage keeps re-presenting the same branch; ignore it.
        if (!freeze) begin
          pc_d    = saved_target_q;
          flush_d = 1'b1;
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= RUN;
      pc_q           <= RESET_PC;
      saved_target_q <= '0;
      taken_count_q  <= '0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      saved_target_q <= saved_target_d;
      taken_count_q  <= taken_count_d;
    end
  end

  assign pc              = pc_q;
  assign flush           = flush_d && !rst;
  assign redirectPending = (state_q == PENDING);
  assign takenCount      = taken_count_q;

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Random plus directed stimulus for pc_redirect_unit, checked every cycle
// against a behavioural model of the fetch/redirect rules.
module tb_pc_redirect_unit;

  logic        clk = 1'b0;
  logic        rst, freeze, brCond;
  logic [31:0] brTarget;
  logic [31:0] pc, pcPlus4;
  logic        flush, redirectPending;
  logic [15:0] takenCount;

  int checks = 0;
  int errors = 0;

  // model state
  bit          m_valid = 0;
  bit          m_pend;
  logic [31:0] m_pc, m_saved;
  int          m_cnt;

  always #5 clk = ~clk;

  pc_redirect_unit dut (
    .clk(clk), .rst(rst), .freeze(freeze), .brCond(brCond), .brTarget(brTarget),
    .pc(pc), .pcPlus4(pcPlus4), .flush(flush), .redirectPending(redirectPending),
    .takenCount(takenCount)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle's inputs, check outputs, then advance model and DUT one edge.
  task automatic step(input bit r, input bit f, input bit b, input logic [31:0] t);
    bit exp_flush;
    rst = r; freeze = f; brCond = b; brTarget = t;
    #1;
    exp_flush = !r && !f && (m_pend || b);
    if (m_valid) begin
      chk("pc", pc, m_pc);
      chk("pcPlus4", pcPlus4, m_pc + 32'd4);
      chk("pending", {31'd0, redirectPending}, {31'd0, m_pend});
      chk("takenCount", {16'd0, takenCount}, m_cnt);
      chk("flush", {31'd0, flush}, {31'd0, exp_flush});
    end else if (r) begin
      chk("flush_in_reset", {31'd0, flush}, 32'd0);
    end
    @(posedge clk);
    if (r) begin
      m_valid = 1; m_pc = 0; m_pend = 0; m_saved = 0; m_cnt = 0;
    end else if (m_valid) begin
      if (!m_pend) begin
        if (b) m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
        if (b && f) begin m_saved = t; m_pend = 1; end
        else if (b) m_pc = t;
        else if (!f) m_pc = m_pc + 32'd4;
      end else if (!f) begin
        m_pc = m_saved; m_pend = 0;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1; freeze = 0; brCond = 0; brTarget = 0;
    @(negedge clk);

    // reset + sequential fetch
    step(1, 0, 0, 0);
    chk("reset_pc", pc, 32'h0);
    chk("reset_pcPlus4", pcPlus4, 32'h4);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
    chk("seq_pc16", pc, 32'd16);

    // unfrozen branch at pc=8
    step(1, 0, 0, 0); step(0, 0, 0, 0); step(0, 0, 0, 0);
    step(0, 0, 1, 32'h40);
    chk("br_pc", pc, 32'h40);
    step(0, 0, 0, 0);
    chk("br_pc_next", pc, 32'h44);
    chk("br_count", {16'd0, takenCount}, 32'd1);

    // branch under freeze, target changes while pending
    step(1, 0, 0, 0); step(0, 0, 0, 0); step(0, 0, 0, 0);
    step(0, 1, 1, 32'h80);
    step(0, 1, 1, 32'hC0);
    step(0, 1, 1, 32'hC0);
    chk("frz_pc", pc, 32'h8);
    chk("frz_pending", {31'd0, redirectPending}, 32'd1);
    step(0, 0, 1, 32'hC0);
    chk("rel_pc", pc, 32'h80);
    chk("rel_count", {16'd0, takenCount}, 32'd1);

    // reset while pending
    step(0, 0, 0, 0);
    step(0, 1, 1, 32'h80);
    step(1, 0, 0, 0);
    chk("rstpend_pc", pc, 32'h0);
    chk("rstpend_pending", {31'd0, redirectPending}, 32'd0);
    step(0, 0, 0, 0); step(0, 0, 0, 0);
    chk("rstpend_seq", pc, 32'h8);

    // wrap at top of address space
    step(0, 0, 1, 32'hFFFF_FFFC);
    chk("wrap_plus4", pcPlus4, 32'h0);
    step(0, 0, 0, 0);
    chk("wrap_pc", pc, 32'h0);

    // random traffic
    for (int i = 0; i < 2000; i++)
      step(($urandom_range(49) == 0), ($urandom_range(2) == 0),
           ($urandom_range(3) == 0), {$urandom} & 32'hFFFF_FFFC);

    // counter saturation
    step(1, 0, 0, 0);
    for (int i = 0; i < 65535; i++) step(0, 0, 1, 32'h100);
    chk("sat_preload", {16'd0, takenCount}, 32'hFFFF);
    step(0, 0, 1, 32'h200);
    step(0, 1, 1, 32'h300);
    step(0, 0, 0, 0);
    chk("sat_hold", {16'd0, takenCount}, 32'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_redirect_unit.md
PC_REDIRECT_UNIT -- requirements
Module: pc_redirect_unit

Interface
REQ-001 The module SHALL have parameter WORD_LEN, default `WORD_LEN (32), setting the address/PC width.
REQ-002 The module SHALL have parameter RESET_PC, default 0, setting the PC value loaded on reset.
REQ-003 Port clk  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst  input  1  is the synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 Port freeze  input  1  is the hazard stall from the hazard unit; when high, the IF stage holds.
REQ-006 Port brCond  input  1  is the taken-branch/jump decision from the ID-stage condition checker.
REQ-007 Port brTarget  input  WORD_LEN  is the resolved branch/jump target address, valid when brCond=1.
REQ-008 Port pc  output  WORD_LEN  is the registered fetch address.
REQ-009 Port pcPlus4  output  WORD_LEN  is combinational pc+4.
REQ-010 Port flush  output  1  is the combinational IF/ID flush, high in any cycle where a redirect target loads into pc.
REQ-011 Port redirectPending  output  1  is high while the module is in state PENDING.
REQ-012 Port takenCount  output  16  is the registered, saturating count of taken redirects.

Function
REQ-013 The module SHALL implement a two-state FSM: RUN and PENDING.
REQ-014 RUN, brCond=0, freeze=0: pc SHALL load pc+4 (modulo 2^WORD_LEN); the FSM SHALL stay in RUN.
REQ-015 RUN, brCond=0, freeze=1: pc SHALL hold; the FSM SHALL stay in RUN.
REQ-016 RUN, brCond=1, freeze=0: pc SHALL load brTarget, flush SHALL be 1 that cycle, and the FSM SHALL stay in RUN.
REQ-017 RUN, brCond=1, freeze=1: brTarget SHALL be captured into an internal savedTarget register, pc SHALL hold, flush SHALL be 0, and the FSM SHALL go to PENDING.
REQ-018 PENDING, freeze=1: pc and savedTarget SHALL hold; brCond and brTarget SHALL be ignored, because the frozen ID stage re-presents the same branch.
REQ-019 PENDING, freeze=0: pc SHALL load savedTarget, flush SHALL be 1 that cycle, and the FSM SHALL return to RUN; brCond and brTarget that cycle SHALL be ignored.
REQ-020 flush SHALL be 0 in every cycle not covered by REQ-016 or REQ-019, and SHALL be 0 whenever rst=1.
REQ-021 takenCount SHALL increment by 1 on each RUN cycle with brCond=1, independent of freeze, and SHALL NOT increment in PENDING; each branch SHALL therefore be counted exactly once.
REQ-022 takenCount SHALL saturate at 16'hFFFF and SHALL NOT wrap.
REQ-023 pcPlus4 SHALL be pc+4 truncated to WORD_LEN bits; pc at 2^WORD_LEN-4 SHALL advance to 0.
REQ-024 redirectPending SHALL be 1 exactly when the FSM is in PENDING.
REQ-025 Redirect latency SHALL be 0 cycles from the unfrozen brCond cycle: the new pc is visible after the same rising edge.

Reset
REQ-026 When rst=1 at a rising edge, the module SHALL set pc=RESET_PC, FSM=RUN, savedTarget=0 and takenCount=0, overriding all other inputs.
REQ-027 A reset asserted while in PENDING SHALL discard the pending redirect; no flush and no load of savedTarget SHALL follow.
REQ-028 After reset: pcPlus4=RESET_PC+4, flush=0, redirectPending=0.

Verification
REQ-029 Sequential fetch: reset, then 4 cycles with freeze=0 and brCond=0 -> pc = 0, 4, 8, 12, 16; flush=0 throughout; takenCount=0.
REQ-030 Unfrozen branch: at pc=8, brCond=1 and brTarget=0x40 for 1 cycle -> flush=1 that cycle, next pc=0x40, then 0x44; takenCount=1.
REQ-031 Branch under freeze: at pc=8, freeze=1 and brCond=1 (target 0x80) for 3 cycles, then freeze=0 -> pc=8 while frozen, redirectPending=1, flush=1 only in the release cycle, next pc=0x80; takenCount=1.
REQ-032 Changing target while pending: in PENDING, brTarget changes to 0xC0 -> release still loads 0x80.
REQ-033 Reset mid-pending: enter PENDING (target 0x80), assert rst for 1 cycle with freeze=0 -> pc=RESET_PC, redirectPending=0, no flush, takenCount=0, then sequential fetch resumes.
REQ-034 Boundaries: start from pc=0xFFFFFFFC -> next pc=0; with takenCount preloaded to 0xFFFF via 65535 taken branches, one more branch -> takenCount stays 0xFFFF.
